// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the oversampled UART blocks.
// Holds the frame FSM state encoding, the prescale floor and the parity
// type encodings used by both transmitter and receiver.
package uart_pkg;

  // Frame state set: IDLE, START, DATA, PARITY, STOP.
  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // Smallest usable number of clock cycles per serial bit.
  localparam int MIN_PRESCALE = 4;

  // Parity type encodings on PAR_TYP.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: per-bit cycle counter for the oversampled transmitter.
// Latches the clamped prescale when a frame is accepted and counts
// 0..pre-1 inside every serial bit while the frame runs. bit_end marks the
// last cycle of a bit, near_end the cycle just before it.
import uart_pkg::*;

module uart_bit_timer #(
  parameter int PRE_WID = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               run,
  input  logic [PRE_WID-1:0] prescale,
  output logic               bit_end,
  output logic               near_end
);

  localparam logic [PRE_WID-1:0] MIN_PRE = PRE_WID'(MIN_PRESCALE);
  localparam logic [PRE_WID-1:0] ONE     = PRE_WID'(1);
  localparam logic [PRE_WID-1:0] TWO     = PRE_WID'(2);

  logic [PRE_WID-1:0] pre_r;
  logic [PRE_WID-1:0] cyc_r;
  logic [PRE_WID-1:0] eff_pre_s;

  // Clamp the requested prescale up to the minimum usable value.
  always_comb begin
    eff_pre_s = prescale;
    if (prescale < MIN_PRE) begin
      eff_pre_s = MIN_PRE;
    end else begin
      eff_pre_s = prescale;
    end
  end

  assign bit_end  = run && (cyc_r == (pre_r - ONE));
  assign near_end = run && (cyc_r == (pre_r - TWO));

  // Prescale latch on accept; cycle counter wraps at the end of each bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r <= '0;
      cyc_r <= '0;
    end else if (load) begin
      pre_r <= eff_pre_s;
      cyc_r <= '0;
    end else if (run) begin
      if (cyc_r == (pre_r - ONE)) begin
        cyc_r <= '0;
      end else begin
        cyc_r <= cyc_r + ONE;
      end
    end else begin
      cyc_r <= cyc_r;
    end
  end

endmodule

// File: rtl/uart_tx_os.sv
// uart_tx_os: oversampled UART transmitter running on the receiver clock.
// Frame: start, DATA_WID data bits LSB first, optional parity, stop.
// Each serial bit is held for max(Prescale, 4) clock cycles. TX_OUT, Busy
// and Done are registered; Done pulses on the final stop-bit cycle.
// Build option: define UART_TX_TWO_STOP_EN for two stop bits per frame.
import uart_pkg::*;

module uart_tx_os #(
  parameter int DATA_WID = 8,
  parameter int PRE_WID  = 6
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [DATA_WID-1:0] P_DATA,
  input  logic                DATA_VALID,
  input  logic                PAR_EN,
  input  logic                PAR_TYP,
  input  logic [PRE_WID-1:0]  Prescale,
  output logic                TX_OUT,
  output logic                Busy,
  output logic                Done
);

  localparam int BIDX_WID = (DATA_WID > 1) ? $clog2(DATA_WID) : 1;
  localparam logic [BIDX_WID-1:0] BIDX_LAST = BIDX_WID'(DATA_WID - 1);

  state_t              state_r, state_nxt_s;
  logic                tx_r, tx_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                done_r, done_nxt_s;
  logic [BIDX_WID-1:0] bidx_r, bidx_nxt_s, bidx_inc_s;
  logic [DATA_WID-1:0] data_r;
  logic                par_en_r;
  logic                par_typ_r;
  logic                accept_s;
  logic                run_s;
  logic                bit_end_s;
  logic                near_end_s;
  logic                final_stop_s;
  logic                parity_s;

  // Parity bit for a data word: XOR of the bits, inverted for odd parity.
  function automatic logic calc_parity(input logic [DATA_WID-1:0] d, input logic typ);
    return (typ == PAR_ODD) ? ~(^d) : (^d);
  endfunction

  assign run_s      = (state_r != ST_IDLE);
  assign bidx_inc_s = bidx_r + BIDX_WID'(1);
  assign parity_s   = calc_parity(data_r, par_typ_r);

  uart_bit_timer #(
    .PRE_WID (PRE_WID)
  ) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept_s),
    .run      (run_s),
    .prescale (Prescale),
    .bit_end  (bit_end_s),
    .near_end (near_end_s)
  );

`ifdef UART_TX_TWO_STOP_EN
  logic stop_cnt_r;

  // Tracks which of the two stop bits is being sent.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stop_cnt_r <= 1'b0;
    end else if (accept_s) begin
      stop_cnt_r <= 1'b0;
    end else if ((state_r == ST_STOP) && bit_end_s) begin
      stop_cnt_r <= ~stop_cnt_r;
    end else begin
      stop_cnt_r <= stop_cnt_r;
    end
  end

  assign final_stop_s = stop_cnt_r;
`else
  assign final_stop_s = 1'b1;
`endif

  // Next-state and next-output logic; outputs are the values for the next cycle.
  always_comb begin
    state_nxt_s = state_r;
    tx_nxt_s    = tx_r;
    busy_nxt_s  = busy_r;
    done_nxt_s  = 1'b0;
    bidx_nxt_s  = bidx_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (DATA_VALID) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_START;
          tx_nxt_s    = 1'b0;
          busy_nxt_s  = 1'b1;
          bidx_nxt_s  = '0;
        end else begin
          tx_nxt_s   = 1'b1;
          busy_nxt_s = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_nxt_s = ST_DATA;
          tx_nxt_s    = data_r[0];
          bidx_nxt_s  = '0;
        end else begin
          tx_nxt_s = 1'b0;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          if (bidx_r == BIDX_LAST) begin
            if (par_en_r) begin
              state_nxt_s = ST_PARITY;
              tx_nxt_s    = parity_s;
            end else begin
              state_nxt_s = ST_STOP;
              tx_nxt_s    = 1'b1;
            end
          end else begin
            bidx_nxt_s = bidx_inc_s;
            tx_nxt_s   = data_r[bidx_inc_s];
          end
        end else begin
          tx_nxt_s = data_r[bidx_r];
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_nxt_s = ST_STOP;
          tx_nxt_s    = 1'b1;
        end else begin
          tx_nxt_s = parity_s;
        end
      end
      ST_STOP: begin
        tx_nxt_s   = 1'b1;
        done_nxt_s = near_end_s && final_stop_s;
        if (bit_end_s && final_stop_s) begin
          state_nxt_s = ST_IDLE;
          busy_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_STOP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        tx_nxt_s    = 1'b1;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, output registers and the per-frame data/config latch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      bidx_r    <= '0;
      data_r    <= '0;
      par_en_r  <= 1'b0;
      par_typ_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tx_r    <= tx_nxt_s;
      busy_r  <= busy_nxt_s;
      done_r  <= done_nxt_s;
      bidx_r  <= bidx_nxt_s;
      if (accept_s) begin
        data_r    <= P_DATA;
        par_en_r  <= PAR_EN;
        par_typ_r <= PAR_TYP;
      end else begin
        data_r    <= data_r;
        par_en_r  <= par_en_r;
        par_typ_r <= par_typ_r;
      end
    end
  end

  assign TX_OUT = tx_r;
  assign Busy   = busy_r;
  assign Done   = done_r;

endmodule
